// File: rtl/uart_baud_generator_2.sv
// UART baud-rate generator, 16x oversampling.
// Divides clk by N = floor(F / (16*B)) and steps a 4-bit oversample index.
//
// Ports:
//   clk                         in   system clock, rising edge
//   rst                         in   async active-high reset
//   Baud_Rate_Holding_Register  in   baud rate B (bit/s)
//   clock_frequency_register    in   clk frequency F (Hz)
//   sampling_pulse              out  oversample index 0..15 (8 = mid-bit)

`timescale 1ns/1ps

module uart_baud_generator_2 #(
    parameter int REG_W    = 32,
    parameter int OSR_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_W-1:0]    Baud_Rate_Holding_Register,
    input  logic [REG_W-1:0]    clock_frequency_register,
    output logic [OSR_LOG2-1:0] sampling_pulse
);

    localparam int DW = REG_W + OSR_LOG2;
    localparam int IW = $clog2(REG_W);
    localparam logic [IW-1:0] ITER_LAST = IW'(REG_W - 1);

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_CALC,
        S_RUN,
        S_IDLE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [REG_W-1:0]    r_baud;
    logic [REG_W-1:0]    r_freq;
    logic [DW-1:0]       r_div;
    logic [DW-1:0]       r_rem;
    logic [REG_W-1:0]    r_quo;
    logic [IW-1:0]       r_iter;
    logic [REG_W-1:0]    r_n;
    logic [REG_W-1:0]    r_cnt;
    logic [OSR_LOG2-1:0] r_pulse;

    logic                w_cfg_changed;
    logic                w_baud_zero;
    logic                w_iter_last;
    logic [DW:0]         w_trial;
    logic                w_ge;
    logic [DW-1:0]       w_sub;
    logic [DW-1:0]       w_rem_next;
    logic [REG_W-1:0]    w_quo_next;
    logic [REG_W-1:0]    w_n_load;
    logic                w_cnt_wrap;

    assign w_cfg_changed =
        (Baud_Rate_Holding_Register != r_baud) ||
        (clock_frequency_register   != r_freq);

    assign w_baud_zero = (Baud_Rate_Holding_Register == '0);
    assign w_iter_last = (r_iter == ITER_LAST);

    // Restoring divider step: the dividend MSBs are shifted out of r_quo
    // into the partial remainder while quotient bits shift in at the LSB.
    // When the trial fits, the difference is below r_div, so modulo-2^DW
    // subtraction on the low bits is exact.
    assign w_trial    = {r_rem, r_quo[REG_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_div});
    assign w_sub      = w_trial[DW-1:0] - r_div;
    assign w_rem_next = w_ge ? w_sub : w_trial[DW-1:0];
    assign w_quo_next = {r_quo[REG_W-2:0], w_ge};

    // F < 16*B would give a zero divisor; run at the fastest rate instead.
    assign w_n_load = (w_quo_next == '0) ? REG_W'(1) : w_quo_next;

    assign w_cnt_wrap = (r_cnt == r_n - REG_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_CAPTURE: begin
                w_next_state = w_baud_zero ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                if (w_iter_last) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_cfg_changed) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_IDLE: begin
                if (w_cfg_changed) begin
                    w_next_state = S_CAPTURE;
                end
            end
            default: begin
                w_next_state = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud  <= '0;
            r_freq  <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_iter  <= '0;
            r_n     <= REG_W'(1);
            r_cnt   <= '0;
            r_pulse <= '0;
        end else begin
            unique case (r_state)
                S_CAPTURE: begin
                    r_baud  <= Baud_Rate_Holding_Register;
                    r_freq  <= clock_frequency_register;
                    r_div   <= {Baud_Rate_Holding_Register,
                                {OSR_LOG2{1'b0}}};
                    r_rem   <= '0;
                    r_quo   <= clock_frequency_register;
                    r_iter  <= '0;
                    r_cnt   <= '0;
                    r_pulse <= '0;
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_iter  <= r_iter + IW'(1);
                    r_pulse <= '0;
                    if (w_iter_last) begin
                        r_n   <= w_n_load;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_cfg_changed) begin
                        r_cnt   <= '0;
                        r_pulse <= '0;
                    end else if (w_cnt_wrap) begin
                        r_cnt   <= '0;
                        r_pulse <= r_pulse + OSR_LOG2'(1);
                    end else begin
                        r_cnt   <= r_cnt + REG_W'(1);
                    end
                end
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_pulse <= '0;
                end
                default: begin
                    r_cnt   <= '0;
                    r_pulse <= '0;
                end
            endcase
        end
    end

    assign sampling_pulse = r_pulse;

endmodule

// File: tb/tb_uart_baud_generator_2.sv
// Testbench for uart_baud_generator_2.
// Reference: pulse at edge e = floor((e-33)/N) mod 16, N = max(1, F/(16B)).

`timescale 1ns/1ps

module tb_uart_baud_generator_2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] baud = 32'd0;
    logic [31:0] freq = 32'd0;
    logic [3:0]  pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_baud_generator_2 #(
        .REG_W    (32),
        .OSR_LOG2 (4)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .Baud_Rate_Holding_Register (baud),
        .clock_frequency_register   (freq),
        .sampling_pulse             (pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned model_n(
        input logic [31:0] f,
        input logic [31:0] b
    );
        longint unsigned q;
        q = {32'd0, f} / ({32'd0, b} * 64'd16);
        if (q == 0) q = 1;
        return q;
    endfunction

    function automatic logic [3:0] model_pulse(
        input longint unsigned e,
        input longint unsigned n
    );
        if (e < 33) return 4'd0;
        return 4'(((e - 33) / n) % 16);
    endfunction

    task automatic start_reset(input logic [31:0] f, input logic [31:0] b);
        rst  = 1'b1;
        freq = f;
        baud = b;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        freq = 32'd100_000_000;
        baud = 32'd9600;
        #1;
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL reset_initial got=%0d want=0", pulse);
        end
        repeat (10) tick();
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL reset_held got=%0d want=0", pulse);
        end
    endtask

    task automatic test_9600();
        longint unsigned n;
        longint unsigned pts[4] = '{683, 684, 5241, 10449};
        logic [3:0] vals[4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        logic [3:0] exp_v;
        bit bad = 0;
        start_reset(32'd100_000_000, 32'd9600);
        n = model_n(freq, baud);
        for (longint unsigned e = 1; e <= 10455; e++) begin
            tick();
            exp_v = model_pulse(e, n);
            if (!bad) begin
                checks++;
                if (pulse !== exp_v) begin
                    failures++;
                    bad = 1;
                    $display("FAIL b9600_model edge=%0d got=%0d want=%0d",
                             e, pulse, exp_v);
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (e == pts[j]) begin
                    checks++;
                    if (pulse !== vals[j]) begin
                        failures++;
                        $display("FAIL b9600_point edge=%0d got=%0d want=%0d",
                                 e, pulse, vals[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_n_one(input logic [31:0] f, input logic [31:0] b);
        longint unsigned n;
        logic [3:0] exp_v;
        bit bad = 0;
        start_reset(f, b);
        n = model_n(f, b);
        for (longint unsigned e = 1; e <= 73; e++) begin
            tick();
            exp_v = model_pulse(e, n);
            if (!bad) begin
                checks++;
                if (pulse !== exp_v) begin
                    failures++;
                    bad = 1;
                    $display("FAIL n_one f=%0d b=%0d edge=%0d got=%0d want=%0d",
                             f, b, e, pulse, exp_v);
                end
            end
        end
    endtask

    task automatic test_baud_zero();
        longint unsigned n;
        logic [3:0] exp_v;
        bit bad = 0;
        start_reset(32'd100_000_000, 32'd0);
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (!bad) begin
                checks++;
                if (pulse !== 4'd0) begin
                    failures++;
                    bad = 1;
                    $display("FAIL bzero_idle edge=%0d got=%0d want=0",
                             e, pulse);
                end
            end
        end
        baud = 32'd9600;
        tick();
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL bzero_change_edge got=%0d want=0", pulse);
        end
        n = model_n(freq, baud);
        bad = 0;
        for (longint unsigned e = 1; e <= 700; e++) begin
            tick();
            exp_v = model_pulse(e, n);
            if (!bad) begin
                checks++;
                if (pulse !== exp_v) begin
                    failures++;
                    bad = 1;
                    $display("FAIL bzero_resume edge=%0d got=%0d want=%0d",
                             e, pulse, exp_v);
                end
            end
        end
    endtask

    task automatic test_reconfig();
        longint unsigned n;
        logic [3:0] exp_v;
        bit bad = 0;
        checks++;
        if (pulse !== 4'd1) begin
            failures++;
            $display("FAIL reconfig_before got=%0d want=1", pulse);
        end
        baud = 32'd115200;
        tick();
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL reconfig_clear got=%0d want=0", pulse);
        end
        n = model_n(freq, baud);
        for (longint unsigned e = 1; e <= 901; e++) begin
            tick();
            exp_v = model_pulse(e, n);
            if (!bad) begin
                checks++;
                if (pulse !== exp_v) begin
                    failures++;
                    bad = 1;
                    $display("FAIL reconfig_model edge=%0d got=%0d want=%0d",
                             e, pulse, exp_v);
                end
            end
            if (e == 86 || e == 87) begin
                checks++;
                if (pulse !== ((e == 87) ? 4'd1 : 4'd0)) begin
                    failures++;
                    $display("FAIL reconfig_point edge=%0d got=%0d", e, pulse);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_v;
        bit bad = 0;
        start_reset(32'd16, 32'd1);
        repeat (38) tick();
        checks++;
        if (pulse !== 4'd5) begin
            failures++;
            $display("FAIL async_pre got=%0d want=5", pulse);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL async_immediate got=%0d want=0", pulse);
        end
        tick();
        tick();
        checks++;
        if (pulse !== 4'd0) begin
            failures++;
            $display("FAIL async_held got=%0d want=0", pulse);
        end
        rst = 1'b0;
        for (longint unsigned e = 1; e <= 60; e++) begin
            tick();
            exp_v = model_pulse(e, 1);
            if (!bad) begin
                checks++;
                if (pulse !== exp_v) begin
                    failures++;
                    bad = 1;
                    $display("FAIL async_restart edge=%0d got=%0d want=%0d",
                             e, pulse, exp_v);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [31:0] b;
        longint unsigned n;
        longint unsigned len;
        logic [3:0] exp_v;
        bit bad;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                b = $urandom_range(5000, 1);
                f = $urandom_range(b * 16 * 12 + 15, 0);
            end else begin
                b = $urandom_range(32'h0800_0000, 32'h0100_0000);
                f = $urandom;
            end
            if (f == freq && b == baud) f = f + 32'd1;
            freq = f;
            baud = b;
            tick();
            checks++;
            if (pulse !== 4'd0) begin
                failures++;
                $display("FAIL rand_clear i=%0d got=%0d want=0", i, pulse);
            end
            n = model_n(f, b);
            len = 33 + 16 * n + 4;
            bad = 0;
            for (longint unsigned e = 1; e <= len; e++) begin
                tick();
                exp_v = model_pulse(e, n);
                if (!bad) begin
                    checks++;
                    if (pulse !== exp_v) begin
                        failures++;
                        bad = 1;
                        $display("FAIL rand f=%0d b=%0d edge=%0d got=%0d want=%0d",
                                 f, b, e, pulse, exp_v);
                    end
                end
            end
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_9600();
        test_n_one(32'd16, 32'd1);
        test_n_one(32'd100, 32'd10);
        test_baud_zero();
        test_reconfig();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_baud_generator_2.md
Name: uart_baud_generator_2

Overview:
- UART baud-rate generator with 16x oversampling.
- Computes a clock prescale divisor from two 32-bit configuration registers: system clock frequency in Hz and baud rate in bit/s.
- Outputs a free-running 4-bit oversample index (0..15) that advances once per 1/16 bit period.
- Sits between the UART configuration registers and the TX/RX bit engines. An index value of 8 marks mid-bit, which RX uses as its sample point.

Parameters:
- REG_W, 32, width of the frequency and baud configuration inputs.
- OSR_LOG2, 4, log2 of the oversampling ratio (16x). Fixed; sampling_pulse width equals OSR_LOG2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- Baud_Rate_Holding_Register  input  32  baud rate B in bit/s.
- clock_frequency_register  input  32  clk frequency F in Hz.
- sampling_pulse  output  4  oversample tick index within the current bit period.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is rst, asynchronous and active-high.
  - All state is cleared immediately when rst=1 and held cleared while rst=1.
- Reset values:
  - sampling_pulse=0, prescale counter cnt=0, divisor N=1.
  - State=CAPTURE.
  - Latched copies of both configuration inputs=0.
- Divisor: N = floor(F / (16*B)).
  - Denominator is B zero-extended and shifted left 4, giving 36 bits.
  - Computed by a sequential restoring divider, 1 quotient bit per clock, 32 iterations. No combinational divide.
  - Quotient is 32 bits.
  - If the quotient is 0 (F < 16*B), N is forced to 1.
- State machine:
  - CAPTURE: one edge. Latch B and F, load the divider operands, go to CALC. If latched B==0, go to IDLE instead.
  - CALC: 32 edges, one divider iteration each. On the 32nd iteration edge, load N, clear cnt, go to RUN.
  - RUN: each edge, if cnt==N-1 then cnt<=0 and sampling_pulse<=sampling_pulse+1 (mod 16, wraps 15->0); else cnt<=cnt+1.
  - IDLE: counters and sampling_pulse held at 0. Leave to CAPTURE when either input differs from its latched copy.
- Reconfiguration:
  - In RUN, if either input differs from its latched copy on an edge, go to CAPTURE on that edge.
  - That same edge clears cnt and sampling_pulse.
- During CAPTURE and CALC, sampling_pulse is held at 0.
- Timing:
  - Reset release (or reconfiguration) edge 1 is CAPTURE.
  - Edges 2..33 are the CALC iterations; edge 33 enters RUN.
  - sampling_pulse becomes k at edge 33 + k*N, for k=1..15.
  - It wraps to 0 at edge 33 + 16*N, then repeats with period 16*N.
- N=1 boundary: sampling_pulse increments on every RUN edge.
- Inputs are treated as quasi-static. Changes during CALC are ignored until RUN, then trigger reconfiguration.
- sampling_pulse is a registered output with no combinational path from the inputs.

Test Plan:
- F=100_000_000, B=9600, release rst: N=651. sampling_pulse=0 through edge 683, 1 at edge 684, 8 (4'b1000) at edge 5241, 0 (wrap) at edge 10449.
- F=16, B=1: N=1. After edge 33, sampling_pulse counts 1,2,...,15,0 on consecutive edges.
- F=100, B=10 (16*B > F): N forced to 1. Same behaviour as the previous scenario.
- B=0: sampling_pulse stays 0 indefinitely. Then set B=9600 with F=100e6: normal counting resumes, value 1 at 651+33 edges after the change edge.
- In RUN, change B from 9600 to 115200: sampling_pulse clears to 0 on the change edge. New N=54; value 1 appears 33+54 edges later.
- Assert rst asynchronously mid-count (sampling_pulse=5): output goes 0 immediately, without waiting for a clk edge. After release the timing restarts from CAPTURE.
